// File: rtl/multi_port_axi_bridge.sv
// multi_port_axi_bridge
// Bridges NPORT SRAM-like requester ports onto one AXI3 master. Reads and
// writes run through independent FSMs, each with at most one transaction in
// flight. Arbitration is round-robin (separate read/write pointers) or fixed
// priority, selected by RR_EN_DEFAULT.
// Optional feature: define BRIDGE_RAW_CHECK_EN to hold back any read whose
// word address matches a write still in W_SEND/W_RESP.
// NPORT must be 1..4; port indices are carried in 2 bits.

module multi_port_axi_bridge #(
    parameter int NPORT         = 2,
    parameter int RR_EN_DEFAULT = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    // requester ports
    input  logic [NPORT-1:0]     req,
    input  logic [NPORT-1:0]     wr,
    input  logic [2*NPORT-1:0]   size,
    input  logic [32*NPORT-1:0]  addr,
    input  logic [32*NPORT-1:0]  wdata,
    input  logic [4*NPORT-1:0]   wstrb,
    output logic [NPORT-1:0]     addr_ok,
    output logic [NPORT-1:0]     data_ok,
    output logic [31:0]          rdata,
    // AXI read address channel
    output logic [3:0]           arid,
    output logic [31:0]          araddr,
    output logic [3:0]           arlen,
    output logic [2:0]           arsize,
    output logic [1:0]           arburst,
    output logic [1:0]           arlock,
    output logic [3:0]           arcache,
    output logic [2:0]           arprot,
    output logic                 arvalid,
    input  logic                 arready,
    // AXI read data channel
    input  logic [3:0]           rid,
    input  logic [31:0]          axi_rdata,
    input  logic                 rvalid,
    output logic                 rready,
    // AXI write address channel
    output logic [3:0]           awid,
    output logic [31:0]          awaddr,
    output logic [3:0]           awlen,
    output logic [2:0]           awsize,
    output logic [1:0]           awburst,
    output logic [1:0]           awlock,
    output logic [3:0]           awcache,
    output logic [2:0]           awprot,
    output logic                 awvalid,
    input  logic                 awready,
    // AXI write data channel
    output logic [3:0]           wid,
    output logic [31:0]          axi_wdata,
    output logic [3:0]           axi_wstrb,
    output logic                 wlast,
    output logic                 wvalid,
    input  logic                 wready,
    // AXI write response channel
    input  logic [3:0]           bid,
    input  logic                 bvalid,
    output logic                 bready
);

    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_SEND, W_RESP} w_state_t;

    r_state_t r_state_q, r_state_d;
    w_state_t w_state_q, w_state_d;

    logic [1:0]       r_ptr_q, w_ptr_q;
    logic [NPORT-1:0] busy_q;

    logic [1:0]  r_owner_q, w_owner_q;
    logic [31:0] r_addr_q, w_addr_q, w_data_q;
    logic [1:0]  r_size_q, w_size_q;
    logic [3:0]  w_strb_q;
    logic        aw_done_q, w_done_q;

    logic [NPORT-1:0] r_elig, w_elig, raw_block;
    logic             r_found, w_found, r_grant, w_grant;
    logic [1:0]       r_pick, w_pick;
    logic [31:0]      r_addr_sel, w_addr_sel, w_data_sel;
    logic [1:0]       r_size_sel, w_size_sel;
    logic [3:0]       w_strb_sel;

    // Write responses are matched by the stored owner, so the returned id is
    // not needed.
    logic unused_bid;
    assign unused_bid = ^bid;

    // Scan eligible ports starting at 'start', wrapping; returns {found, index}.
    // Iterating downward lets the smallest offset overwrite the result last.
    function automatic logic [2:0] arbitrate(input logic [NPORT-1:0] elig,
                                             input logic [1:0] start);
        logic [2:0]       res;
        logic [NPORT-1:0] shifted;
        int               idx;
        res = 3'b000;
        for (int k = NPORT - 1; k >= 0; k--) begin
            idx     = (int'(start) + k) % NPORT;
            shifted = elig >> idx;
            if (shifted[0]) res = {1'b1, 2'(idx)};
        end
        return res;
    endfunction

    // Pointer advance: (granted index + 1) mod NPORT.
    function automatic logic [1:0] next_ptr(input logic [1:0] pick);
        return (pick == 2'(NPORT - 1)) ? 2'd0 : pick + 2'd1;
    endfunction

    // Read-after-write hazard mask: reads to a word still being written wait.
`ifdef BRIDGE_RAW_CHECK_EN
    always_comb begin
        raw_block = '0;
        for (int i = 0; i < NPORT; i++) begin
            raw_block[i] = (w_state_q != W_IDLE) &&
                           (addr[32*i+2 +: 30] == w_addr_q[31:2]);
        end
    end
`else
    assign raw_block = '0;
`endif

    // Arbitration for both paths, plus the combinational accept/completion pulses.
    always_comb begin
        // NOTE: every variable gets a default before any branch so no latch is inferred.
        r_elig = req & ~wr & ~busy_q & ~raw_block;
        w_elig = req &  wr & ~busy_q;
        {r_found, r_pick} = arbitrate(r_elig, (RR_EN_DEFAULT != 0) ? r_ptr_q : 2'd0);
        {w_found, w_pick} = arbitrate(w_elig, (RR_EN_DEFAULT != 0) ? w_ptr_q : 2'd0);
        // Reset must silence addr_ok even while requests are being presented.
        r_grant = r_found && (r_state_q == R_IDLE) && !reset;
        w_grant = w_found && (w_state_q == W_IDLE) && !reset;
        addr_ok = '0;
        data_ok = '0;
        for (int i = 0; i < NPORT; i++) begin
            addr_ok[i] = (r_grant && (r_pick == 2'(i))) ||
                         (w_grant && (w_pick == 2'(i)));
            data_ok[i] = (rvalid && rready && (rid == 4'(i))) ||
                         (bvalid && bready && (w_owner_q == 2'(i)));
        end
    end

    // Select the winning port's request fields for capture at grant.
    always_comb begin
        r_addr_sel = '0;
        r_size_sel = '0;
        w_addr_sel = '0;
        w_size_sel = '0;
        w_data_sel = '0;
        w_strb_sel = '0;
        for (int i = 0; i < NPORT; i++) begin
            if (r_pick == 2'(i)) begin
                r_addr_sel = addr[32*i +: 32];
                r_size_sel = size[2*i +: 2];
            end
            if (w_pick == 2'(i)) begin
                w_addr_sel = addr[32*i +: 32];
                w_size_sel = size[2*i +: 2];
                w_data_sel = wdata[32*i +: 32];
                w_strb_sel = wstrb[4*i +: 4];
            end
        end
    end

    // Read FSM next state and channel outputs.
    always_comb begin
        r_state_d = r_state_q;
        arvalid   = 1'b0;
        rready    = 1'b0;
        case (r_state_q)
            R_IDLE: if (r_grant) r_state_d = R_ADDR;
            R_ADDR: begin
                arvalid = 1'b1;
                if (arready) r_state_d = R_DATA;
            end
            R_DATA: begin
                rready = 1'b1;
                if (rvalid) r_state_d = R_IDLE;
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    // Write FSM next state and channel outputs; AW and W may finish in any order.
    always_comb begin
        w_state_d = w_state_q;
        awvalid   = 1'b0;
        wvalid    = 1'b0;
        bready    = 1'b0;
        case (w_state_q)
            W_IDLE: if (w_grant) w_state_d = W_SEND;
            W_SEND: begin
                awvalid = !aw_done_q;
                wvalid  = !w_done_q;
                if ((aw_done_q || awready) && (w_done_q || wready)) w_state_d = W_RESP;
            end
            W_RESP: begin
                bready = 1'b1;
                if (bvalid) w_state_d = W_IDLE;
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    // Control state: FSMs, pointers, busy flags, owners and handshake progress.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state_q <= R_IDLE;
            w_state_q <= W_IDLE;
            r_ptr_q   <= 2'd0;
            w_ptr_q   <= 2'd0;
            busy_q    <= '0;
            r_owner_q <= 2'd0;
            w_owner_q <= 2'd0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            r_state_q <= r_state_d;
            w_state_q <= w_state_d;
            busy_q    <= (busy_q | addr_ok) & ~data_ok;
            if (r_grant) begin
                r_ptr_q   <= next_ptr(r_pick);
                r_owner_q <= r_pick;
            end
            if (w_grant) begin
                w_ptr_q   <= next_ptr(w_pick);
                w_owner_q <= w_pick;
                aw_done_q <= 1'b0;
                w_done_q  <= 1'b0;
            end else if (w_state_q == W_SEND) begin
                if (awvalid && awready) aw_done_q <= 1'b1;
                if (wvalid && wready)   w_done_q  <= 1'b1;
            end
        end
    end

    // Request payload captured at grant.
    // NOTE: payload registers have no reset; they are only observed behind a valid.
    always_ff @(posedge clk) begin
        if (r_grant) begin
            r_addr_q <= r_addr_sel;
            r_size_q <= r_size_sel;
        end
        if (w_grant) begin
            w_addr_q <= w_addr_sel;
            w_size_q <= w_size_sel;
            w_data_q <= w_data_sel;
            w_strb_q <= w_strb_sel;
        end
    end

    assign rdata     = axi_rdata;

    assign arid      = {2'b00, r_owner_q};
    assign araddr    = r_addr_q;
    assign arsize    = {1'b0, r_size_q};
    assign arlen     = 4'd0;
    assign arburst   = 2'b01;
    assign arlock    = 2'b00;
    assign arcache   = 4'd0;
    assign arprot    = 3'd0;

    assign awid      = {2'b00, w_owner_q};
    assign awaddr    = w_addr_q;
    assign awsize    = {1'b0, w_size_q};
    assign awlen     = 4'd0;
    assign awburst   = 2'b01;
    assign awlock    = 2'b00;
    assign awcache   = 4'd0;
    assign awprot    = 3'd0;

    assign wid       = awid;
    assign axi_wdata = w_data_q;
    assign axi_wstrb = w_strb_q;
    assign wlast     = 1'b1;

endmodule

// File: tb/tb_multi_port_axi_bridge.sv
// Self-checking bench for multi_port_axi_bridge (NPORT=2, round-robin).
// Inputs are driven on the falling edge; outputs are sampled 1 ns later.

module tb_multi_port_axi_bridge;

    localparam int NPORT = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                reset;
    logic [NPORT-1:0]    req, wr;
    logic [2*NPORT-1:0]  size;
    logic [32*NPORT-1:0] addr, wdata;
    logic [4*NPORT-1:0]  wstrb;
    logic [NPORT-1:0]    addr_ok, data_ok;
    logic [31:0]         rdata;
    logic [3:0]  arid, arlen, arcache, rid, awid, awlen, awcache, wid, axi_wstrb, bid;
    logic [31:0] araddr, awaddr, axi_rdata, axi_wdata;
    logic [2:0]  arsize, arprot, awsize, awprot;
    logic [1:0]  arburst, arlock, awburst, awlock;
    logic        arvalid, arready, rvalid, rready, awvalid, awready;
    logic        wlast, wvalid, wready, bvalid, bready;

    multi_port_axi_bridge #(.NPORT(NPORT), .RR_EN_DEFAULT(1)) dut (
        .clk(clk), .reset(reset),
        .req(req), .wr(wr), .size(size), .addr(addr), .wdata(wdata), .wstrb(wstrb),
        .addr_ok(addr_ok), .data_ok(data_ok), .rdata(rdata),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rid(rid), .axi_rdata(axi_rdata), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wid(wid), .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .wlast(wlast),
        .wvalid(wvalid), .wready(wready),
        .bid(bid), .bvalid(bvalid), .bready(bready)
    );

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic        is_wr;
        int          port;
        logic [31:0] data;
    } exp_t;
    exp_t sb_q[$];

    typedef struct {
        logic        is_wr;
        int          port;
        logic [31:0] a;
        logic [1:0]  sz;
        logic [31:0] d;        // write data, or data the slave returns for a read
        logic [3:0]  strb;
        int          ax_dly;   // cycles of AR/AW valid before ready
        int          w_dly;    // cycles of W valid before ready
        logic [2:0]  exp_axsize;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic sb_push(input logic is_wr, input int port, input logic [31:0] data);
        exp_t e;
        e.is_wr = is_wr;
        e.port  = port;
        e.data  = data;
        sb_q.push_back(e);
    endtask

    // Pop one expectation per data_ok bit seen, lowest port first.
    task automatic observe();
        exp_t e;
        for (int i = 0; i < NPORT; i++) begin
            if (data_ok[i]) begin
                if (sb_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL sb_unexpected: data_ok on port %0d with nothing outstanding", i);
                end else begin
                    e = sb_q.pop_front();
                    check("sb_port", 32'(i), 32'(e.port));
                    if (!e.is_wr) check("sb_rdata", rdata, e.data);
                end
            end
        end
    endtask

    task automatic idle_inputs();
        req = '0; wr = '0;
        arready = 1'b0; rvalid = 1'b0; rid = '0; axi_rdata = '0;
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bid = '0;
    endtask

    task automatic run_read(input vec_t v);
        logic [NPORT-1:0] onehot;
        onehot = NPORT'(1 << v.port);
        @(negedge clk);
        req = onehot; wr = '0;
        addr[32*v.port +: 32] = v.a;
        size[2*v.port +: 2]   = v.sz;
        #1;
        check("rd_addr_ok", 32'(addr_ok), 32'(onehot));
        sb_push(1'b0, v.port, v.d);
        for (int c = 0; c <= v.ax_dly; c++) begin
            @(negedge clk);
            req = '0;
            arready = (c == v.ax_dly);
            #1;
            check("rd_arvalid", 32'(arvalid), 32'd1);
            if (c == 0) begin
                check("rd_araddr", araddr, v.a);
                check("rd_arsize", 32'(arsize), 32'(v.exp_axsize));
                check("rd_arid", 32'(arid), 32'(v.port));
                check("rd_arlen_burst", {arlen, arburst}, {4'd0, 2'b01});
            end
        end
        @(negedge clk);
        arready = 1'b0; rvalid = 1'b1; rid = 4'(v.port); axi_rdata = v.d;
        #1;
        check("rd_arvalid_drop", 32'(arvalid), 32'd0);
        check("rd_rready", 32'(rready), 32'd1);
        check("rd_data_ok", 32'(data_ok), 32'(onehot));
        observe();
        @(negedge clk);
        rvalid = 1'b0;
        #1;
        check("rd_data_ok_end", 32'(data_ok), 32'd0);
        check("rd_rready_end", 32'(rready), 32'd0);
    endtask

    task automatic run_write(input vec_t v);
        logic [NPORT-1:0] onehot;
        int n;
        onehot = NPORT'(1 << v.port);
        n = (v.ax_dly > v.w_dly) ? v.ax_dly : v.w_dly;
        @(negedge clk);
        req = onehot; wr = onehot;
        addr[32*v.port +: 32]  = v.a;
        size[2*v.port +: 2]    = v.sz;
        wdata[32*v.port +: 32] = v.d;
        wstrb[4*v.port +: 4]   = v.strb;
        #1;
        check("wr_addr_ok", 32'(addr_ok), 32'(onehot));
        sb_push(1'b1, v.port, 32'd0);
        for (int c = 0; c <= n; c++) begin
            @(negedge clk);
            req = '0; wr = '0;
            awready = (c == v.ax_dly);
            wready  = (c == v.w_dly);
            #1;
            check("wr_awvalid", 32'(awvalid), 32'(c <= v.ax_dly));
            check("wr_wvalid", 32'(wvalid), 32'(c <= v.w_dly));
            if (c == 0) begin
                check("wr_awaddr", awaddr, v.a);
                check("wr_awsize", 32'(awsize), 32'(v.exp_axsize));
                check("wr_awid_wid", {awid, wid}, {4'(v.port), 4'(v.port)});
                check("wr_wdata", axi_wdata, v.d);
                check("wr_wstrb_wlast", {axi_wstrb, wlast}, {v.strb, 1'b1});
            end
        end
        @(negedge clk);
        awready = 1'b0; wready = 1'b0; bvalid = 1'b1; bid = 4'(v.port);
        #1;
        check("wr_bready", 32'(bready), 32'd1);
        check("wr_valids_low", {awvalid, wvalid}, 2'b00);
        check("wr_data_ok", 32'(data_ok), 32'(onehot));
        observe();
        @(negedge clk);
        bvalid = 1'b0;
        #1;
        check("wr_data_ok_end", 32'(data_ok), 32'd0);
        check("wr_bready_end", 32'(bready), 32'd0);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        idle_inputs();
        reset = 1'b1;
        sb_q.delete();
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Global watchdog so a wedged run still ends with a report.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[6];
        vecs[0] = '{1'b0, 0, 32'h0000_1000, 2'd2, 32'hDEAD_BEEF, 4'h0, 0, 0, 3'd2};
        vecs[1] = '{1'b0, 1, 32'h0000_2468, 2'd1, 32'h1234_5678, 4'h0, 2, 0, 3'd1};
        vecs[2] = '{1'b0, 0, 32'hFFFF_FFFC, 2'd0, 32'hA5A5_5A5A, 4'h0, 1, 0, 3'd0};
        vecs[3] = '{1'b1, 1, 32'h0000_2004, 2'd2, 32'hCAFE_F00D, 4'b0011, 2, 0, 3'd2};
        vecs[4] = '{1'b1, 0, 32'h0000_0010, 2'd1, 32'h0BAD_BEEF, 4'b1100, 0, 3, 3'd1};
        vecs[5] = '{1'b1, 1, 32'h8000_0000, 2'd0, 32'h1111_2222, 4'b0001, 1, 1, 3'd0};

        idle_inputs();
        size = '0; addr = '0; wdata = '0; wstrb = '0;
        reset = 1'b1;

        // Reset state, with requests already presented.
        repeat (2) @(negedge clk);
        req = 2'b11;
        #1;
        check("rst_addr_ok", 32'(addr_ok), 32'd0);
        check("rst_data_ok", 32'(data_ok), 32'd0);
        check("rst_valids", {arvalid, awvalid, wvalid}, 3'b000);
        check("rst_readies", {rready, bready}, 2'b00);
        @(negedge clk);
        req = '0;
        reset = 1'b0;

        // Single-transaction vectors.
        for (int i = 0; i < 6; i++) begin
            if (vecs[i].is_wr) run_write(vecs[i]);
            else               run_read(vecs[i]);
        end

        // Read on port 0 and write on port 1 completing in the same cycle.
        @(negedge clk);
        req = 2'b11; wr = 2'b10;
        addr = {32'h0000_6000, 32'h0000_5000}; size = 4'b1010;
        wdata[63:32] = 32'h7777_7777; wstrb[7:4] = 4'hF;
        #1;
        check("dual_addr_ok", 32'(addr_ok), 32'd3);
        sb_push(1'b0, 0, 32'h9999_0000);
        sb_push(1'b1, 1, 32'd0);
        @(negedge clk);
        req = '0; wr = '0; arready = 1'b1; awready = 1'b1; wready = 1'b1;
        #1;
        check("dual_valids", {arvalid, awvalid, wvalid}, 3'b111);
        check("dual_ids", {arid, awid}, {4'd0, 4'd1});
        @(negedge clk);
        arready = 1'b0; awready = 1'b0; wready = 1'b0;
        rvalid = 1'b1; rid = 4'd0; axi_rdata = 32'h9999_0000;
        bvalid = 1'b1; bid = 4'd1;
        #1;
        check("dual_data_ok", 32'(data_ok), 32'd3);
        observe();
        @(negedge clk);
        rvalid = 1'b0; bvalid = 1'b0;
        #1;
        check("dual_data_ok_end", 32'(data_ok), 32'd0);

        // Read to the word of an in-flight write.
        @(negedge clk);
        req = 2'b01; wr = 2'b01;
        addr[31:0] = 32'h0000_3000; size[1:0] = 2'd2;
        wdata[31:0] = 32'h0303_0303; wstrb[3:0] = 4'hF;
        #1;
        check("raw_wr_addr_ok", 32'(addr_ok), 32'd1);
        sb_push(1'b1, 0, 32'd0);
        @(negedge clk);
        req = 2'b10; wr = 2'b00;
        addr[63:32] = 32'h0000_3002; size[3:2] = 2'd2;
        #1;
        check("raw_wr_in_send", 32'(awvalid), 32'd1);
`ifdef BRIDGE_RAW_CHECK_EN
        check("raw_rd_held_send", 32'(addr_ok), 32'd0);
        @(negedge clk);
        awready = 1'b1; wready = 1'b1;
        #1;
        check("raw_rd_held_hs", 32'(addr_ok), 32'd0);
        @(negedge clk);
        awready = 1'b0; wready = 1'b0; bvalid = 1'b1; bid = 4'd0;
        #1;
        check("raw_rd_held_bvalid", 32'(addr_ok), 32'd0);
        check("raw_wr_data_ok", 32'(data_ok), 32'd1);
        observe();
        @(negedge clk);
        bvalid = 1'b0;
        #1;
        check("raw_rd_granted", 32'(addr_ok), 32'd2);
`else
        check("raw_rd_granted", 32'(addr_ok), 32'd2);
`endif
        pulse_reset();

        // Reset while in R_DATA abandons the read without a completion pulse.
        @(negedge clk);
        req = 2'b01; wr = 2'b00; addr[31:0] = 32'h0000_4000;
        #1;
        check("rstmid_addr_ok", 32'(addr_ok), 32'd1);
        sb_push(1'b0, 0, 32'd0);
        @(negedge clk);
        req = '0; arready = 1'b1;
        #1;
        check("rstmid_arvalid", 32'(arvalid), 32'd1);
        @(negedge clk);
        arready = 1'b0;
        #1;
        check("rstmid_rready", 32'(rready), 32'd1);
        reset = 1'b1;
        rvalid = 1'b1; rid = 4'd0; axi_rdata = 32'h0BAD_0BAD;
        #1;
        check("rstmid_arvalid_rready", {arvalid, rready}, 2'b00);
        check("rstmid_no_data_ok", 32'(data_ok), 32'd0);
        sb_q.delete();
        @(negedge clk);
        rvalid = 1'b0;
        reset = 1'b0;

        // Both ports reading continuously: grants and ids alternate 0,1,0,1.
        @(negedge clk);
        req = 2'b11; wr = 2'b00; arready = 1'b1;
        addr = {32'h0000_0200, 32'h0000_0100};
        for (int k = 0; k < 4; k++) begin
            int p;
            p = k % 2;
            #1;
            check("rr_addr_ok", 32'(addr_ok), 32'(1 << p));
            sb_push(1'b0, p, 32'hC0DE_0000 + 32'(k));
            @(negedge clk);
            #1;
            check("rr_arid", 32'(arid), 32'(p));
            check("rr_araddr", araddr, (p == 0) ? 32'h0000_0100 : 32'h0000_0200);
            @(negedge clk);
            rvalid = 1'b1; rid = 4'(p); axi_rdata = 32'hC0DE_0000 + 32'(k);
            #1;
            check("rr_data_ok", 32'(data_ok), 32'(1 << p));
            observe();
            @(negedge clk);
            rvalid = 1'b0;
            if (k == 3) req = '0;
        end
        arready = 1'b0;

        @(negedge clk);
        check("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/multi_port_axi_bridge.md
MULTI_PORT_AXI_BRIDGE -- requirements
Module: multi_port_axi_bridge

Interface
REQ-001 SHALL have parameter NPORT, default 2, number of SRAM-like requester ports (legal 1..4).
REQ-002 SHALL have parameter RR_EN_DEFAULT, default 1: 1 = round-robin arbitration, 0 = fixed priority with lowest index winning.
REQ-003 clk  in  1  single clock; all logic rising-edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 req / wr  in  NPORT each  per-port request and write flag.
REQ-006 size  in  2*NPORT  per-port byte size code: 0=1B, 1=2B, 2=4B.
REQ-007 addr / wdata  in  32*NPORT each  per-port address and write data.
REQ-008 wstrb  in  4*NPORT  per-port write byte strobes.
REQ-009 addr_ok / data_ok  out  NPORT each  per-port request-accept and completion pulses.
REQ-010 rdata  out  32  read data, broadcast to all ports.
REQ-011 AXI master: arid/awid 4, araddr/awaddr 32, arsize/awsize 3, arvalid/awvalid out; arready/awready in; rid 4, rdata 32, rvalid in; rready out; wdata 32, wstrb 4, wvalid out; wready in; bid 4, bvalid in; bready out.
REQ-012 Constant AXI outputs: arlen/awlen=0, arburst/awburst=2'b01, lock/cache/prot=0, wlast=1, wid=awid.

Function
REQ-013 Read and write paths SHALL be independent FSMs, each with at most one AXI transaction in flight.
REQ-014 A port SHALL hold at most one outstanding request; a busy port SHALL NOT be granted until its data_ok.
REQ-015 Read FSM states: R_IDLE -> R_ADDR on grant; R_ADDR -> R_DATA on arvalid&arready; R_DATA -> R_IDLE on rvalid.
REQ-016 Write FSM states: W_IDLE -> W_SEND on grant; W_SEND -> W_RESP once both the AW and W handshakes are done, in either order or in the same cycle; W_RESP -> W_IDLE on bvalid.
REQ-017 Grant SHALL occur only in the idle state, among non-busy ports with req=1 and matching wr; the winner's addr_ok SHALL be driven combinationally high in that same cycle.
REQ-018 Each round-robin pointer SHALL be set to (granted index + 1) mod NPORT after a grant; read and write paths SHALL keep separate pointers.
REQ-019 addr, size, wdata and wstrb SHALL be registered at grant; AXI valids SHALL assert the following cycle and hold until their handshake.
REQ-020 AXI size SHALL be {1'b0,size}; arid/awid SHALL equal the granted port index.
REQ-021 rready SHALL be 1 only in R_DATA; bready SHALL be 1 only in W_RESP.
REQ-022 data_ok[i] SHALL be driven combinationally: high when rvalid & rready & rid==i, or bvalid & bready & the write owner is i.
REQ-023 rdata output SHALL pass AXI rdata through unregistered.
REQ-024 A read and a write completing in the same cycle for different ports SHALL both pulse their data_ok.
REQ-025 Minimum read latency: addr_ok in cycle 0, arvalid in cycle 1, data_ok earliest in cycle 2.

Reset
REQ-026 On reset: both FSMs idle; pointers 0; busy flags clear.
REQ-027 On reset: arvalid, awvalid, wvalid, rready, bready, addr_ok and data_ok all 0.
REQ-028 Reset asserted mid-transaction SHALL abandon the transaction immediately, with no completion pulse; responses arriving after reset deassertion are the system's responsibility.

Configuration
REQ-029 Macro BRIDGE_RAW_CHECK_EN defined: a read SHALL NOT be granted while a write is in W_SEND/W_RESP whose addr[31:2] equals the read's addr[31:2]; that read is granted no earlier than the cycle after bvalid.
REQ-030 BRIDGE_RAW_CHECK_EN undefined: no address comparison; reads are granted regardless of any in-flight write.

Verification
REQ-031 Port0 read addr 0x1000, size 2; slave arready=1, rvalid one cycle later with 0xDEADBEEF -> addr_ok[0] cycle 0, arvalid cycle 1, data_ok[0] with rdata=0xDEADBEEF cycle 2.
REQ-032 NPORT=2, RR on, both ports read continuously -> grants alternate 0,1,0,1; arid follows 0,1,0,1.
REQ-033 Port1 write 0x2004, wstrb 4'b0011; awready delayed 3 cycles, wready immediate -> wvalid drops after 1 cycle, awvalid held 3 cycles, data_ok[1] on bvalid.
REQ-034 With BRIDGE_RAW_CHECK_EN: port0 write 0x3000, then port1 read 0x3002 -> read addr_ok withheld until the cycle after bvalid; without the macro, read granted immediately.
REQ-035 Reset asserted while in R_DATA -> arvalid/rready 0 immediately; after release, a new read completes normally.
REQ-036 Read rvalid and write bvalid in the same cycle for ports 0 and 1 -> data_ok = 2'b11 in that cycle.
